// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory master: access sizes, FSM states and the size-to-mask helper.
package lsu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] size_mask(input size_e size);
        logic [XLEN-1:0] m;
        case (size)
            SIZE_B:  m = 64'h0000_0000_0000_00FF;
            SIZE_H:  m = 64'h0000_0000_0000_FFFF;
            SIZE_W:  m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_size_decode.sv
// Size decode: byte-lane read mask and natural-alignment check for one request.
// Latency: combinational. Backpressure: none (pure decode).
// Used on the incoming request so the mask is captured with it and the alignment check gates issue.
module lsu_size_decode
    import lsu_pkg::*;
(
    input  size_e             size,
    input  logic [2:0]        addr,
    output logic [XLEN-1:0]   r_mask,
    output logic              misaligned
);

    logic [2:0] align_bits;

    always_comb begin
        align_bits = 3'b000;
        case (size)
            SIZE_B:  align_bits = 3'b000;
            SIZE_H:  align_bits = 3'b001;
            SIZE_W:  align_bits = 3'b011;
            default: align_bits = 3'b111;
        endcase
    end

    assign r_mask     = size_mask(size);
    assign misaligned = |(addr & align_bits);

endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory master: one load/store request -> held mem_* access -> single response. Optional LSU_MISALIGN_TRAP_EN.
// Latency: accept cycle + ACCESS_LAT access cycles, response in the next cycle (ACCESS_LAT+1 after accept).
// Backpressure: one transaction in flight; req_ready low until the response handshake completes.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ACCESS_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_w_en,
    output logic              mem_signed_en,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_w_data,
    output logic [XLEN-1:0]   mem_r_mask,
    input  logic [XLEN-1:0]   mem_r_data
);

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_LAT - 1);

    state_e            state;
    logic              wen_q;
    logic              signed_q;
    logic [XLEN-1:0]   addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   mask_q;
    logic [3:0]        cnt;

    size_e             req_size_e;
    logic [XLEN-1:0]   req_mask;
    logic              req_misaligned;
    logic              trap;

    assign req_size_e = size_e'(req_size);

    lsu_size_decode u_size_decode (
        .size       (req_size_e),
        .addr       (req_addr[2:0]),
        .r_mask     (req_mask),
        .misaligned (req_misaligned)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = req_misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = req_misaligned;
    assign trap              = 1'b0;
`endif

    // Handshake strobes are qualified with reset so nothing leaks out while it is held low.
    assign req_ready     = reset && (state == IDLE);
    assign resp_valid    = reset && (state == RESP);
    assign mem_en        = reset && (state == ACCESS);
    assign mem_w_en      = mem_en && wen_q && (cnt == 4'd0);
    assign mem_signed_en = signed_q;
    assign mem_addr      = addr_q;
    assign mem_w_data    = wdata_q;
    assign mem_r_mask    = mask_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            wen_q      <= 1'b0;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            cnt        <= 4'd0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        signed_q <= req_signed && !req_wen && (req_size_e != SIZE_D);
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        mask_q   <= req_mask;
                        resp_err <= trap;
                        if (trap) begin
                            resp_rdata <= '0;
                            state      <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_rdata <= wen_q ? '0 : mem_r_data;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: three instances (ACCESS_LAT 1, 3, 4) share stimulus and a byte memory model.
module tb_lsu_mem_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;

    logic        req_ready     [3];
    logic        resp_valid    [3];
    logic [63:0] resp_rdata    [3];
    logic        resp_err      [3];
    logic        mem_en        [3];
    logic        mem_w_en      [3];
    logic        mem_signed_en [3];
    logic [63:0] mem_addr      [3];
    logic [63:0] mem_w_data    [3];
    logic [63:0] mem_r_mask    [3];
    logic [63:0] mem_r_data    [3];
    logic        sbit          [3];

    logic [7:0]  mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;

    int          r_lat, r_en, r_we, r_bp;
    logic [63:0] r_rdata, r_mask;
    logic        r_err, r_sgn, r_rdy;

    always #5 clock = ~clock;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            lsu_mem_master #(.ACCESS_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
                .clock         (clock),
                .reset         (reset),
                .req_valid     (req_valid),
                .req_ready     (req_ready[g]),
                .req_wen       (req_wen),
                .req_size      (req_size),
                .req_signed    (req_signed),
                .req_addr      (req_addr),
                .req_wdata     (req_wdata),
                .resp_valid    (resp_valid[g]),
                .resp_ready    (resp_ready),
                .resp_rdata    (resp_rdata[g]),
                .resp_err      (resp_err[g]),
                .mem_en        (mem_en[g]),
                .mem_w_en      (mem_w_en[g]),
                .mem_signed_en (mem_signed_en[g]),
                .mem_addr      (mem_addr[g]),
                .mem_w_data    (mem_w_data[g]),
                .mem_r_mask    (mem_r_mask[g]),
                .mem_r_data    (mem_r_data[g])
            );
        end
    endgenerate

    // Little-endian byte memory, 64-byte window, written on the byte lanes the mask enables.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_w_en[i]) begin
                for (int b = 0; b < 8; b++) begin
                    if (mem_r_mask[i][8*b])
                        mem[mem_addr[i][5:0] + 6'(b)] <= mem_w_data[i][8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            mem_r_data[i] = '0;
            sbit[i]       = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (mem_r_mask[i][8*b])
                    mem_r_data[i][8*b +: 8] = mem[mem_addr[i][5:0] + 6'(b)];
            end
            for (int b = 1; b < 8; b++) begin
                if (mem_r_mask[i][8*b-1] && !mem_r_mask[i][8*b])
                    sbit[i] = mem_r_data[i][8*b-1];
            end
            if (mem_signed_en[i] && sbit[i])
                mem_r_data[i] = mem_r_data[i] | ~mem_r_mask[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, want 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;
    endtask

    // One full transaction observed on instance k; results land in the r_* variables.
    task automatic txn(input int k, input logic wen, input logic [1:0] size, input logic sgn,
                       input logic [63:0] addr, input logic [63:0] wdata, input int hold);
        do_reset();
        req_wen    = wen;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        r_lat = -1; r_en = 0; r_we = 0; r_bp = 0;
        r_mask = '0; r_sgn = 1'b0; r_rdata = '0; r_err = 1'b0; r_rdy = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_en[k]) begin
                r_en++;
                r_mask = mem_r_mask[k];
                r_sgn  = mem_signed_en[k];
            end
            if (mem_w_en[k]) r_we++;
            if (resp_valid[k]) begin
                r_lat = c;
                break;
            end
            step();
        end
        r_rdata = resp_rdata[k];
        r_err   = resp_err[k];
        if (r_lat > 0) begin
            for (int h = 0; h < hold; h++) begin
                step();
                if (!resp_valid[k] || resp_rdata[k] !== r_rdata || resp_err[k] !== r_err ||
                    req_ready[k] || mem_en[k])
                    r_bp++;
            end
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        if (mem_en[k]) r_en++;
        r_rdy = req_ready[k];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int wbad, rvbad;
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'h8000_0000;
        req_wdata  = '0;
        resp_ready = 1'b0;

        // Reset held with a request offered: nothing may be accepted or issued.
        for (int c = 0; c < 3; c++) begin
            step();
            for (int i = 0; i < 3; i++)
                check($sformatf("rst_hold_c%0d_i%0d", c, i),
                      {61'd0, req_ready[i], mem_en[i], resp_valid[i]}, 64'd0);
        end
        check("rst_addr_q",  mem_addr[2],   64'd0);
        check("rst_rdata",   resp_rdata[2], 64'd0);
        reset     = 1'b1;
        req_valid = 1'b0;
        step();
        check("rst_release_rdy", {63'd0, req_ready[0]}, 64'd1);

        // LAT=1 store D then load D.
        txn(0, 1'b1, 2'd3, 1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788, 0);
        check("st_d_lat",   64'(r_lat), 64'd2);
        check("st_d_wen",   64'(r_we),  64'd1);
        check("st_d_en",    64'(r_en),  64'd1);
        check("st_d_mask",  r_mask,     64'hFFFF_FFFF_FFFF_FFFF);
        check("st_d_rdata", r_rdata,    64'd0);
        txn(0, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0, 0);
        check("ld_d_lat",   64'(r_lat), 64'd2);
        check("ld_d_wen",   64'(r_we),  64'd0);
        check("ld_d_rdata", r_rdata,    64'h1122_3344_5566_7788);

        // LAT=3 byte store of 0x80, then signed byte load.
        txn(1, 1'b1, 2'd0, 1'b0, 64'h8000_0010, 64'h0000_0000_0000_0080, 0);
        check("st_b_lat",   64'(r_lat), 64'd4);
        check("st_b_wen",   64'(r_we),  64'd1);
        txn(1, 1'b0, 2'd0, 1'b1, 64'h8000_0010, 64'd0, 0);
        check("ld_b_lat",   64'(r_lat), 64'd4);
        check("ld_b_en",    64'(r_en),  64'd3);
        check("ld_b_mask",  r_mask,     64'hFF);
        check("ld_b_sgn",   {63'd0, r_sgn}, 64'd1);
        check("ld_b_rdata", r_rdata,    64'hFFFF_FFFF_FFFF_FF80);

        // LAT=4 unsigned word load.
        txn(2, 1'b0, 2'd2, 1'b0, 64'h8000_0000, 64'd0, 0);
        check("ld_w_lat",   64'(r_lat), 64'd5);
        check("ld_w_mask",  r_mask,     64'hFFFF_FFFF);
        check("ld_w_rdata", r_rdata,    64'h0000_0000_5566_7788);

        // Response backpressure for 5 cycles.
        txn(0, 1'b0, 2'd3, 1'b0, 64'h8000_0000, 64'd0, 5);
        check("bp_stable",  64'(r_bp),  64'd0);
        check("bp_en",      64'(r_en),  64'd1);
        check("bp_rdata",   r_rdata,    64'h1122_3344_5566_7788);
        check("bp_rdy_after", {63'd0, r_rdy}, 64'd1);

        // Misaligned word load.
        txn(0, 1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'd0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("mis_lat",    64'(r_lat), 64'd1);
        check("mis_err",    {63'd0, r_err}, 64'd1);
        check("mis_rdata",  r_rdata,    64'd0);
        check("mis_en",     64'(r_en),  64'd0);
`else
        check("mis_lat",    64'(r_lat), 64'd2);
        check("mis_err",    {63'd0, r_err}, 64'd0);
        check("mis_rdata",  r_rdata,    64'h0000_0000_3344_5566);
        check("mis_en",     64'(r_en),  64'd1);
`endif

        // LAT=4 store aborted by reset in its second access cycle.
        do_reset();
        req_wen    = 1'b1;
        req_size   = 2'd3;
        req_signed = 1'b0;
        req_addr   = 64'h8000_0018;
        req_wdata  = 64'h0000_0000_0000_DEAD;
        req_valid  = 1'b1;
        step();
        req_valid = 1'b0;
        wbad  = mem_w_en[2] ? 1 : 0;
        rvbad = resp_valid[2] ? 1 : 0;
        step();
        check("abort_in_access", {63'd0, mem_en[2]}, 64'd1);
        reset = 1'b0;
        #1;
        if (mem_w_en[2]) wbad++;
        for (int c = 0; c < 10; c++) begin
            if (c == 2) reset = 1'b1;
            step();
            if (mem_w_en[2])   wbad++;
            if (resp_valid[2]) rvbad++;
        end
        check("abort_wen",  64'(wbad),  64'd0);
        check("abort_resp", 64'(rvbad), 64'd0);
        check("abort_rdy",  {63'd0, req_ready[2]}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
